// File: rtl/pad_controller.sv
// Paddle position controller: accelerating up/down motion with wall clamping,
// remote-position follow and hold modes. Define PAD_AI_EN to add ball-tracking AI on mode 2'b10.
module pad_controller #(
    parameter int unsigned Y_W         = 10,
    parameter int unsigned SCREEN_H    = 768,
    parameter int unsigned PAD_H       = 145,
    parameter int unsigned Y_INIT      = 312,
    parameter int unsigned V_MIN       = 2,
    parameter int unsigned V_MAX       = 8,
    parameter int unsigned ACCEL_TICKS = 4,
    parameter int unsigned DEADBAND    = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           timing_tick_i,
    input  logic [1:0]     mode_i,
    input  logic           btn_up_i,
    input  logic           btn_down_i,
    input  logic [Y_W-1:0] y_remote_i,
    input  logic [Y_W-1:0] y_ball_i,
    output logic [Y_W-1:0] y_pad_o,
    output logic [3:0]     velocity_o,
    output logic           moving_o
);

    localparam int unsigned Y_MAX = SCREEN_H - PAD_H;
    localparam int unsigned CNT_W = (ACCEL_TICKS > 1) ? $clog2(ACCEL_TICKS) : 1;

    localparam logic [1:0] MODE_LOCAL  = 2'b00;
    localparam logic [1:0] MODE_REMOTE = 2'b01;
    localparam logic [1:0] MODE_AI     = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_UP   = 2'd1;
    localparam logic [1:0] S_DOWN = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [3:0]       vel_q, vel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic             moving_q, moving_d;

    logic [1:0]       mode_eff_c;
    logic             req_up_c, req_dn_c, same_c;
    logic [Y_W-1:0]   step_c;
    logic [Y_W:0]     sum_c;

`ifdef PAD_AI_EN
    logic signed [Y_W:0] ai_raw_c;
    logic [Y_W-1:0]      ai_target_c, ai_dist_c;
    logic                ai_below_c;

    assign mode_eff_c = mode_i;

    // Target is the pad top that centres the pad on the ball, clamped to the playfield.
    always_comb begin
        ai_raw_c = $signed({1'b0, y_ball_i}) - $signed((Y_W+1)'(PAD_H / 2));
        if (ai_raw_c < 0)
            ai_target_c = '0;
        else if (ai_raw_c > $signed((Y_W+1)'(Y_MAX)))
            ai_target_c = Y_W'(Y_MAX);
        else
            ai_target_c = ai_raw_c[Y_W-1:0];
        ai_below_c = ai_target_c > y_q;
        ai_dist_c  = ai_below_c ? (ai_target_c - y_q) : (y_q - ai_target_c);
    end
`else
    logic unused_ball;

    assign unused_ball = ^y_ball_i;
    assign mode_eff_c  = (mode_i == MODE_AI) ? MODE_HOLD : mode_i;
`endif

    // Direction request. The AI deadband only gates starting a move; once moving it
    // continues until the distance is zero so the pad lands exactly on target.
    always_comb begin
        req_up_c = 1'b0;
        req_dn_c = 1'b0;
        case (mode_eff_c)
            MODE_LOCAL: begin
                req_up_c = btn_up_i & ~btn_down_i;
                req_dn_c = btn_down_i & ~btn_up_i;
            end
`ifdef PAD_AI_EN
            MODE_AI: begin
                if ((ai_dist_c != '0) &&
                    (((mode_q == MODE_AI) && (state_q != S_IDLE)) || (ai_dist_c > Y_W'(DEADBAND)))) begin
                    req_dn_c = ai_below_c;
                    req_up_c = ~ai_below_c;
                end
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        vel_d    = vel_q;
        cnt_d    = cnt_q;
        y_d      = y_q;
        step_c   = '0;
        sum_c    = '0;
        same_c   = (mode_eff_c == mode_q) &&
                   ((req_up_c && (state_q == S_UP)) || (req_dn_c && (state_q == S_DOWN)));
        if (timing_tick_i) begin
            mode_d = mode_eff_c;
            if (req_up_c || req_dn_c) begin
                if (same_c) begin
                    if (cnt_q == CNT_W'(ACCEL_TICKS - 1)) begin
                        cnt_d = '0;
                        vel_d = (vel_q >= 4'(V_MAX)) ? 4'(V_MAX) : vel_q + 4'd1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = req_up_c ? S_UP : S_DOWN;
                    vel_d   = 4'(V_MIN);
                    cnt_d   = '0;
                end
                step_c = Y_W'(vel_d);
`ifdef PAD_AI_EN
                if ((mode_eff_c == MODE_AI) && (ai_dist_c < step_c))
                    step_c = ai_dist_c;
`endif
                // Clamp at the walls; the ramp keeps running while pinned.
                if (req_up_c) begin
                    y_d = (y_q < step_c) ? '0 : (y_q - step_c);
                end else begin
                    sum_c = {1'b0, y_q} + {1'b0, step_c};
                    y_d   = (sum_c > (Y_W+1)'(Y_MAX)) ? Y_W'(Y_MAX) : sum_c[Y_W-1:0];
                end
            end else begin
                state_d = S_IDLE;
                vel_d   = '0;
                cnt_d   = '0;
                if (mode_eff_c == MODE_REMOTE)
                    y_d = (y_remote_i > Y_W'(Y_MAX)) ? Y_W'(Y_MAX) : y_remote_i;
            end
        end
        moving_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mode_q   <= MODE_LOCAL;
            vel_q    <= '0;
            cnt_q    <= '0;
            y_q      <= Y_W'(Y_INIT);
            moving_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            vel_q    <= vel_d;
            cnt_q    <= cnt_d;
            y_q      <= y_d;
            moving_q <= moving_d;
        end
    end

    assign y_pad_o    = y_q;
    assign velocity_o = vel_q;
    assign moving_o   = moving_q;

endmodule

// File: tb/tb_pad_controller.sv
// Directed self-checking bench for pad_controller; AI expectations follow PAD_AI_EN.
module tb_pad_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       timing_tick;
    logic [1:0] mode;
    logic       btn_up, btn_down;
    logic [9:0] y_remote, y_ball;
    logic [9:0] y_pad;
    logic [3:0] velocity;
    logic       moving;

    int vectors = 0;
    int miscompares = 0;

    pad_controller dut (
        .clk          (clk),
        .rst          (rst),
        .timing_tick_i(timing_tick),
        .mode_i       (mode),
        .btn_up_i     (btn_up),
        .btn_down_i   (btn_down),
        .y_remote_i   (y_remote),
        .y_ball_i     (y_ball),
        .y_pad_o      (y_pad),
        .velocity_o   (velocity),
        .moving_o     (moving)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        timing_tick = 1'b1;
        @(posedge clk);
        #1;
        timing_tick = 1'b0;
    endtask

    task automatic check_pad(input string tag, input int y, input int v, input int m);
        check({tag, ".y"}, int'(y_pad), y);
        check({tag, ".v"}, int'(velocity), v);
        check({tag, ".m"}, int'(moving), m);
    endtask

    int exp_v[10] = '{2, 2, 2, 2, 3, 3, 3, 3, 4, 4};
    int exp_y[10] = '{314, 316, 318, 320, 323, 326, 329, 332, 336, 340};
    int max_y;

    initial begin
        // reset wins over a simultaneous tick with a button held
        rst = 1'b1; timing_tick = 1'b1; mode = 2'b00;
        btn_up = 1'b0; btn_down = 1'b1; y_remote = '0; y_ball = '0;
        repeat (3) @(posedge clk);
        #1;
        check_pad("reset", 312, 0, 0);
        rst = 1'b0; timing_tick = 1'b0; btn_down = 1'b0;

        repeat (3) tick();
        check_pad("idle3", 312, 0, 0);

        btn_down = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("ramp%0d.v", i), int'(velocity), exp_v[i]);
            check($sformatf("ramp%0d.y", i), int'(y_pad), exp_y[i]);
        end
        check("ramp.m", int'(moving), 1);
        btn_down = 1'b0;
        tick();
        check_pad("release", 340, 0, 0);

        btn_down = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        check_pad("no_tick", 340, 0, 0);

        repeat (5) tick();
        check_pad("rev_down", 351, 3, 1);
        btn_down = 1'b0; btn_up = 1'b1;
        tick();
        check_pad("rev_up", 349, 2, 1);
        btn_down = 1'b1;
        tick();
        check_pad("both", 349, 0, 0);

        btn_up = 1'b0;
        repeat (3) tick();
        check_pad("pre_rst", 355, 2, 1);
        rst = 1'b1; timing_tick = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; timing_tick = 1'b0;
        check_pad("mid_rst", 312, 0, 0);
        tick();
        check_pad("post_rst", 314, 2, 1);

        mode = 2'b01; y_remote = 10'd700;
        tick();
        check_pad("remote_hi", 623, 0, 0);
        mode = 2'b00;
        tick();
        check_pad("wall_dn", 623, 2, 1);
        mode = 2'b01; y_remote = 10'd3;
        tick();
        check_pad("remote_3", 3, 0, 0);
        mode = 2'b00; btn_down = 1'b0; btn_up = 1'b1;
        tick();
        check_pad("up_1", 1, 2, 1);
        tick();
        check_pad("wall_up", 0, 2, 1);
        repeat (3) tick();
        check_pad("wall_hold", 0, 3, 1);
        mode = 2'b11;
        tick();
        check_pad("hold", 0, 0, 0);

        // AI tracking from the reset position
        btn_up = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mode = 2'b10; y_ball = 10'd600;
        max_y = 0;
        for (int i = 0; i < 45; i++) begin
            tick();
            if (int'(y_pad) > max_y) max_y = int'(y_pad);
        end
`ifdef PAD_AI_EN
        check("ai_max", max_y, 528);
        check_pad("ai_land", 528, 0, 0);
        y_ball = 10'd604;
        tick();
        check_pad("ai_deadband", 528, 0, 0);
        y_ball = 10'd605;
        repeat (3) tick();
        check("ai_fine.y", int'(y_pad), 533);
        check("ai_fine.m", int'(moving), 1);
        tick();
        check_pad("ai_fine_stop", 533, 0, 0);
`else
        check("ai_max", max_y, 312);
        check_pad("ai_off", 312, 0, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
